// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit arbiter.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  localparam int MAX_UDP_PAYLOAD    = 1472;
  localparam int DEFAULT_GAP_CYCLES = 1024;

  // Zero-length and oversize payloads are rejected; compared at 16-bit width.
  function automatic logic len_ok(input logic [15:0] len, input logic [15:0] max_len);
    return (len != 16'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin picker: first requester above last_grant wins, with wrap-around.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    for (int off = N; off >= 1; off--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (((int'(last_grant) + off) % N) == j)) begin
          grant    = '0;
          grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares the UDP core's single transmit channel between NUM_REQ packet sources,
// validating lengths and inserting a fixed idle gap after every packet.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate among req_valid
// LOAD  | latch length/port of granted source; reject bad lengths
// SEND  | stream one payload byte per cycle into the core
// GAP   | fixed idle period so the core can finish framing
module udp_tx_arbiter
  import udp_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int MAX_LEN    = MAX_UDP_PAYLOAD
) (
  input  logic                   udp_clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*16-1:0]  req_length,
  input  logic [NUM_REQ*16-1:0]  req_dst_port,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_data_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_drop,
  output logic [7:0]             user_tx_data,
  output logic                   user_tx_data_valid,
  output logic [15:0]            user_tx_data_length,
  output logic [15:0]            tx_dst_port,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [15:0]      MAX_LEN16 = 16'(MAX_LEN);

  tx_state_t          state, state_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx, grant_idx, last_grant;
  logic [15:0]        byte_cnt, len_sel;
  logic [GAP_W-1:0]   gap_cnt;
  logic               len_good, last_byte, gap_done;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign len_sel   = req_length[16*grant_idx +: 16];
  assign len_good  = len_ok(len_sel, MAX_LEN16);
  assign last_byte = (byte_cnt == 16'd1);
  assign gap_done  = (gap_cnt == '0);

  always_ff @(posedge udp_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_data_ready = '0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (|req_valid) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = len_good ? ST_SEND : ST_IDLE;
      ST_SEND: begin
        req_data_ready = req_grant;
        if (last_byte) state_nxt = ST_GAP;
      end
      ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge udp_clk or negedge reset_n) begin
    if (!reset_n) begin
      req_grant           <= '0;
      grant_idx           <= '0;
      last_grant          <= IDX_W'(NUM_REQ - 1);
      req_done            <= '0;
      req_drop            <= '0;
      byte_cnt            <= '0;
      gap_cnt             <= '0;
      user_tx_data        <= '0;
      user_tx_data_valid  <= 1'b0;
      user_tx_data_length <= '0;
      tx_dst_port         <= '0;
      drop_cnt            <= '0;
    end else begin
      req_done           <= '0;
      req_drop           <= '0;
      user_tx_data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_grant <= pick;
            grant_idx <= pick_idx;
          end
        end
        ST_LOAD: begin
          user_tx_data_length <= len_sel;
          byte_cnt            <= len_sel;
          tx_dst_port         <= req_dst_port[16*grant_idx +: 16];
          if (!len_good) begin
            req_drop   <= req_grant;
            req_grant  <= '0;
            last_grant <= grant_idx;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
        end
        ST_SEND: begin
          user_tx_data       <= req_data[8*grant_idx +: 8];
          user_tx_data_valid <= 1'b1;
          byte_cnt           <= byte_cnt - 16'd1;
          if (last_byte) begin
            req_done   <= req_grant;
            req_grant  <= '0;
            last_grant <= grant_idx;
            gap_cnt    <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt - GAP_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
